// File: rtl/bitmap_layer_renderer.sv
// Bitmap layer line renderer with double-buffered line banks.
// On each line_render_start the front/back banks swap and the new back bank is
// filled from VRAM one 32-bit word at a time, four pixels per word.
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   regs_addr/regs_wrdata/regs_write     register write port
//   regs_rddata                          combinational register read
//   line_idx, line_render_start          line request
//   line_render_done                     one-cycle completion pulse
//   enabled                              front bank valid flag
//   lb_rdidx, lb_rddata                  front bank pixel read (1-cycle latency)
//   bus_addr/bus_strobe/bus_ack/bus_rddata  VRAM word fetch bus
module bitmap_layer_renderer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  regs_addr,
    input  logic [7:0]  regs_wrdata,
    input  logic        regs_write,
    output logic [7:0]  regs_rddata,
    input  logic [8:0]  line_idx,
    input  logic        line_render_start,
    output logic        line_render_done,
    output logic        enabled,
    input  logic [9:0]  lb_rdidx,
    output logic [7:0]  lb_rddata,
    output logic [14:0] bus_addr,
    output logic        bus_strobe,
    input  logic        bus_ack,
    input  logic [31:0] bus_rddata
);
    localparam int unsigned BANK_DEPTH = 640;
    localparam int unsigned BASE_W     = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t              state;
    logic                ctrl_en;
    logic                ctrl_hs;
    logic [BASE_W-1:0]   base;
    logic                line_en;
    logic                line_hs;
    logic [14:0]         line_addr;
    logic                restart;
    logic [7:0]          word_idx;
    logic [1:0]          byte_idx;
    logic [31:0]         word;
    logic                front_sel;
    logic [1:0]          valid;
    logic [1:0]          width_hs;

    logic [7:0]          bank0 [BANK_DEPTH];
    logic [7:0]          bank1 [BANK_DEPTH];

    logic [BASE_W-1:0]   line_off_c;
    logic [14:0]         start_addr_c;
    logic [7:0]          last_word_c;
    logic [9:0]          wr_idx_c;
    logic [7:0]          front_pix_c;
    logic                rd_ok_c;

    // Register file writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en <= 1'b0;
            ctrl_hs <= 1'b0;
            base    <= '0;
        end else if (regs_write) begin
            case (regs_addr)
                2'd0: begin
                    ctrl_en <= regs_wrdata[0];
                    ctrl_hs <= regs_wrdata[1];
                end
                2'd1:    base[7:0]  <= regs_wrdata;
                2'd2:    base[15:8] <= regs_wrdata;
                default: base[16]   <= regs_wrdata[0];
            endcase
        end
    end

    // Register readback
    always_comb begin
        regs_rddata = 8'h00;
        case (regs_addr)
            2'd0:    regs_rddata = {6'b0, ctrl_hs, ctrl_en};
            2'd1:    regs_rddata = base[7:0];
            2'd2:    regs_rddata = base[15:8];
            default: regs_rddata = {7'b0, base[16]};
        endcase
    end

    // line_idx * W via shifts (320 = 256 + 64, 640 = 512 + 128), modulo 2^17
    assign line_off_c   = ctrl_hs ? (17'({line_idx, 8'b0}) + 17'({line_idx, 6'b0}))
                                  : (17'({line_idx, 9'b0}) + 17'({line_idx, 7'b0}));
    assign start_addr_c = 15'((base + line_off_c) >> 2);
    assign last_word_c  = line_hs ? 8'd79 : 8'd159;
    assign wr_idx_c     = {word_idx, byte_idx};

    // Render sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            bus_strobe       <= 1'b0;
            bus_addr         <= '0;
            line_render_done <= 1'b0;
            enabled          <= 1'b0;
            front_sel        <= 1'b0;
            valid            <= '0;
            width_hs         <= '0;
            line_en          <= 1'b0;
            line_hs          <= 1'b0;
            line_addr        <= '0;
            restart          <= 1'b0;
            word_idx         <= '0;
            byte_idx         <= '0;
            word             <= '0;
        end else begin
            line_render_done <= 1'b0;
            if (line_render_start) begin
                // Swap: old back becomes front, old front is the new (invalid) back
                front_sel        <= ~front_sel;
                valid[front_sel] <= 1'b0;
                enabled          <= valid[~front_sel];
                line_en          <= ctrl_en;
                line_hs          <= ctrl_hs;
                line_addr        <= start_addr_c;
                word_idx         <= '0;
                byte_idx         <= '0;
                restart          <= 1'b0;
                if (state == ST_REQ && !bus_ack) begin
                    // Outstanding request must complete before the new line is issued
                    restart <= 1'b1;
                end else if (ctrl_en) begin
                    state      <= ST_REQ;
                    bus_strobe <= 1'b1;
                    bus_addr   <= start_addr_c;
                end else begin
                    state            <= ST_DONE;
                    bus_strobe       <= 1'b0;
                    line_render_done <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_REQ: begin
                        if (bus_ack) begin
                            if (restart) begin
                                // Data of the aborted line is dropped
                                restart <= 1'b0;
                                if (line_en) begin
                                    bus_addr <= line_addr;
                                end else begin
                                    state            <= ST_DONE;
                                    bus_strobe       <= 1'b0;
                                    line_render_done <= 1'b1;
                                end
                            end else begin
                                word       <= bus_rddata;
                                bus_strobe <= 1'b0;
                                byte_idx   <= '0;
                                state      <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_idx <= word_idx + 8'd1;
                            bus_addr <= bus_addr + 15'd1;
                            if (word_idx == last_word_c) begin
                                state               <= ST_DONE;
                                line_render_done    <= 1'b1;
                                valid[~front_sel]   <= 1'b1;
                                width_hs[~front_sel] <= line_hs;
                            end else begin
                                state      <= ST_REQ;
                                bus_strobe <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Back bank pixel writes, one byte of the latched word per WRITE cycle
    always_ff @(posedge clk) begin
        if (state == ST_WRITE) begin
            if (front_sel) begin
                bank0[wr_idx_c] <= word[{byte_idx, 3'b000} +: 8];
            end else begin
                bank1[wr_idx_c] <= word[{byte_idx, 3'b000} +: 8];
            end
        end
    end

    // Front bank read, masked by valid flag and stored width
    assign front_pix_c = front_sel ? bank1[lb_rdidx] : bank0[lb_rdidx];
    assign rd_ok_c     = valid[front_sel] &&
                         (lb_rdidx < (width_hs[front_sel] ? 10'd320 : 10'd640));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_rddata <= 8'h00;
        end else begin
            lb_rddata <= rd_ok_c ? front_pix_c : 8'h00;
        end
    end

endmodule

// File: tb/tb_bitmap_layer_renderer.sv
// Self-checking bench for bitmap_layer_renderer: directed line sequence with
// randomized config, a VRAM responder with programmable ack delay, and a
// bank-level reference model of what the front bank should contain.
module tb_bitmap_layer_renderer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  regs_addr = '0;
    logic [7:0]  regs_wrdata = '0;
    logic        regs_write = 1'b0;
    logic [7:0]  regs_rddata;
    logic [8:0]  line_idx = '0;
    logic        line_render_start = 1'b0;
    logic        line_render_done;
    logic        enabled;
    logic [9:0]  lb_rdidx = '0;
    logic [7:0]  lb_rddata;
    logic [14:0] bus_addr;
    logic        bus_strobe;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rddata = '0;

    bitmap_layer_renderer dut (
        .clk(clk), .rst_n(rst_n),
        .regs_addr(regs_addr), .regs_wrdata(regs_wrdata), .regs_write(regs_write),
        .regs_rddata(regs_rddata),
        .line_idx(line_idx), .line_render_start(line_render_start),
        .line_render_done(line_render_done), .enabled(enabled),
        .lb_rdidx(lb_rdidx), .lb_rddata(lb_rddata),
        .bus_addr(bus_addr), .bus_strobe(bus_strobe), .bus_ack(bus_ack),
        .bus_rddata(bus_rddata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_en = 1'b0, m_hs = 1'b0;
    logic [16:0] m_base = '0;
    bit mf_valid = 0, mb_valid = 0, mb_en = 0;
    int mf_w = 640, mb_w = 640, mf_start = 0, mb_start = 0;
    logic [31:0] vram_seed = '0;

    // Bus/monitor state
    int ack_delay = 0, wait_cnt = 0, exp_hold = 1;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, first_strobe_cyc = 0;
    bit seen_strobe = 0, prev_pending = 0;
    logic [14:0] prev_addr = '0;
    int hold_len = 0, hold_bad = 0, unstable_cnt = 0;
    int acc_q[$];
    int acc_cyc_q[$];
    int ln_acc0 = 0, ln_done0 = 0;

    function automatic logic [31:0] vram(input logic [14:0] a);
        if (a == 15'h0180) return 32'h44332211;
        if (a == 15'h0181) return 32'h88776655;
        return {a, 2'b10, ~a} ^ vram_seed;
    endfunction

    function automatic logic [7:0] pix(input int s, input int p);
        logic [31:0] w;
        w = vram(15'((s + p / 4) % 32768));
        return 8'(w >> (8 * (p % 4)));
    endfunction

    function automatic logic [7:0] exp_rd(input int idx);
        if (!mf_valid || idx >= mf_w) return 8'h00;
        return pix(mf_start, idx);
    endfunction

    function automatic logic [7:0] model_reg(input int a);
        case (a)
            0:       return {6'b0, m_hs, m_en};
            1:       return m_base[7:0];
            2:       return m_base[15:8];
            default: return {7'b0, m_base[16]};
        endcase
    endfunction

    // VRAM responder: ack after ack_delay waiting cycles
    always @(negedge clk) begin
        if (rst_n && bus_strobe && wait_cnt >= ack_delay) begin
            bus_ack    = 1'b1;
            bus_rddata = vram(bus_addr);
        end else begin
            bus_ack    = 1'b0;
            bus_rddata = $urandom;
        end
    end

    // Edge monitor
    always @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt = 0; hold_len = 0; prev_pending = 0;
        end else begin
            if (bus_strobe && !seen_strobe) begin
                first_strobe_cyc = cyc; seen_strobe = 1;
            end
            if (line_render_start) begin
                start_cyc = cyc; seen_strobe = 0;
            end
            if (line_render_done) begin
                done_cyc = cyc; done_cnt++;
            end
            if (bus_strobe) begin
                if (prev_pending && bus_addr != prev_addr) unstable_cnt++;
                hold_len++;
                if (bus_ack) begin
                    acc_q.push_back(int'(bus_addr));
                    acc_cyc_q.push_back(cyc);
                    if (hold_len != exp_hold) hold_bad++;
                    hold_len = 0; prev_pending = 0; wait_cnt = 0;
                end else begin
                    prev_pending = 1; prev_addr = bus_addr; wait_cnt++;
                end
            end else begin
                hold_len = 0; prev_pending = 0; wait_cnt = 0;
            end
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input int a, input logic [7:0] d);
        @(negedge clk);
        regs_addr = 2'(a); regs_wrdata = d; regs_write = 1'b1;
        @(negedge clk);
        regs_write = 1'b0;
        case (a)
            0: begin m_en = d[0]; m_hs = d[1]; end
            1: m_base[7:0] = d;
            2: m_base[15:8] = d;
            default: m_base[16] = d[0];
        endcase
    endtask

    task automatic reg_check(input int a);
        regs_addr = 2'(a);
        #1;
        check($sformatf("reg%0d", a), regs_rddata, model_reg(a));
    endtask

    task automatic set_regs(input logic en, input logic hs, input logic [16:0] b);
        reg_write(0, {6'($urandom), hs, en});
        reg_write(1, b[7:0]);
        reg_write(2, b[15:8]);
        reg_write(3, {7'($urandom), b[16]});
    endtask

    task automatic start_line(input logic [8:0] idx);
        @(negedge clk);
        ln_acc0 = acc_q.size(); ln_done0 = done_cnt;
        line_idx = idx; line_render_start = 1'b1;
        @(negedge clk);
        line_render_start = 1'b0;
        mf_valid = mb_valid; mf_w = mb_w; mf_start = mb_start;
        mb_valid = 0; mb_en = m_en; mb_w = m_hs ? 320 : 640;
        mb_start = ((int'(m_base) + int'(idx) * mb_w) % 131072) / 4;
        check("enabled_after_start", enabled, mf_valid);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4000 && done_cnt == ln_done0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - ln_done0, 1);
        if (done_cnt != ln_done0) mb_valid = mb_en;
    endtask

    task automatic check_line(input int b, input int s, input int nw, input string tag);
        int bad = 0;
        check({tag, "_nreq"}, acc_q.size() - b, nw);
        for (int i = 0; i < nw && b + i < acc_q.size(); i++)
            if (acc_q[b + i] != (s + i) % 32768) bad++;
        check({tag, "_addrseq"}, bad, 0);
    endtask

    task automatic rd_check(input int idx);
        @(negedge clk);
        lb_rdidx = 10'(idx);
        @(posedge clk);
        #1;
        check($sformatf("lb_rd[%0d]", idx), lb_rddata, exp_rd(idx));
    endtask

    int a5, l5_start, d5, n0, l6_b;

    initial begin
        vram_seed = $urandom;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobe", bus_strobe, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_done", line_render_done, 0);
        check("rst_enabled", enabled, 0);
        check("rst_lbdata", lb_rddata, 0);
        for (int a = 0; a < 4; a++) reg_check(a);
        rst_n = 1'b1;

        // Register masking with random data
        for (int i = 0; i < 8; i++) begin
            int a;
            a = $urandom_range(0, 3);
            reg_write(a, 8'($urandom));
            reg_check(a);
        end

        // Line 1: 640 px, base 0x100, line 2, zero-wait
        ack_delay = 0; exp_hold = 1;
        set_regs(1'b1, 1'b0, 17'h00100);
        start_line(9'd2);
        wait_done("l1");
        check("l1_first_addr", acc_q[ln_acc0], 32'h180);
        check_line(ln_acc0, mb_start, 160, "l1");
        check("l1_strobe_lat", first_strobe_cyc - start_cyc, 1);
        check("l1_done_lat", done_cyc - start_cyc, 801);

        // Line 2: 320 px, 3-cycle ack delay; front shows line 1
        ack_delay = 3; exp_hold = 4;
        set_regs(1'b1, 1'b1, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        rd_check(5);
        rd_check(700);
        rd_check(639);
        for (int i = 0; i < 5; i++) rd_check($urandom_range(0, 1023));
        wait_done("l2");
        check_line(ln_acc0, mb_start, 80, "l2");
        check("l2_hold_len", hold_bad, 0);
        check("l2_addr_stable", unstable_cnt, 0);

        // Line 3: 320 px zero-wait; front shows line 2 (width 320)
        ack_delay = 0; exp_hold = 1;
        set_regs(1'b1, 1'b1, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        rd_check(319);
        rd_check(320);
        for (int i = 0; i < 4; i++) rd_check($urandom_range(0, 639));
        wait_done("l3");
        check_line(ln_acc0, mb_start, 80, "l3");
        check("l3_done_lat", done_cyc - start_cyc, 401);

        // Line 4: disabled
        set_regs(1'b0, 1'(($urandom)), 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        rd_check(0);
        rd_check($urandom_range(0, 319));
        wait_done("l4");
        check("l4_done_lat", done_cyc - start_cyc, 1);
        check("l4_no_strobe", seen_strobe, 0);
        check_line(ln_acc0, 0, 0, "l4");

        // Line 5 aborted mid-request by line 6
        ack_delay = 5; exp_hold = 6;
        set_regs(1'b1, 1'b0, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        a5 = ln_acc0; l5_start = mb_start; d5 = ln_done0;
        rd_check($urandom_range(0, 639));
        rd_check(10);
        set_regs(1'b1, 1'(($urandom)), 17'($urandom));
        for (int i = 0; i < 2000 && !((cyc - start_cyc >= 300) && bus_strobe && wait_cnt == 0); i++)
            @(negedge clk);
        check("l5_pending_found", bus_strobe, 1);
        start_line(9'($urandom_range(0, 479)));
        n0 = ln_acc0;
        rd_check($urandom_range(0, 639));
        wait_done("l6");
        begin
            int bad = 0;
            for (int i = a5; i <= n0 && i < acc_q.size(); i++)
                if (acc_q[i] != (l5_start + i - a5) % 32768) bad++;
            check("l5_prefix_addrseq", bad, 0);
        end
        check_line(n0 + 1, mb_start, mb_w / 4, "l6");
        check("abort_reissue_gap", acc_cyc_q[n0 + 1] - acc_cyc_q[n0], 6);
        check("abort_done_count", done_cnt - d5, 1);
        check("abort_hold_len", hold_bad, 0);
        check("abort_addr_stable", unstable_cnt, 0);

        // Line 7: address wrap, config rewritten mid-line
        ack_delay = 0; exp_hold = 1;
        set_regs(1'b1, 1'b0, 17'h1FFFC);
        start_line(9'd0);
        l6_b = ln_acc0;
        reg_write(0, 8'($urandom));
        reg_write(1, 8'($urandom));
        reg_write(3, 8'($urandom));
        for (int i = 0; i < 6; i++) rd_check($urandom_range(0, 700));
        wait_done("l7");
        check("l7_first_addr", acc_q[l6_b], 32'h7FFF);
        check("l7_second_addr", acc_q[l6_b + 1], 32'h0000);
        check_line(l6_b, 32'h7FFF, 160, "l7");

        // Line 8 disabled; front shows line 7
        set_regs(1'b0, 1'b0, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        for (int i = 0; i < 4; i++) rd_check(i);
        rd_check($urandom_range(4, 639));
        wait_done("l8");

        // Reset during an outstanding request
        ack_delay = 4; exp_hold = 5;
        set_regs(1'b1, 1'b1, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        for (int i = 0; i < 50 && !bus_strobe; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_strobe", bus_strobe, 0);
        check("rstmid_addr", bus_addr, 0);
        check("rstmid_enabled", enabled, 0);
        m_en = 0; m_hs = 0; m_base = '0; mf_valid = 0; mb_valid = 0;
        for (int a = 0; a < 4; a++) reg_check(a);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0; exp_hold = 1;
        set_regs(1'b1, 1'b0, 17'($urandom));
        start_line(9'($urandom_range(0, 479)));
        wait_done("postrst");
        check("postrst_strobe_lat", first_strobe_cyc - start_cyc, 1);
        check("postrst_done_lat", done_cyc - start_cyc, 801);
        check_line(ln_acc0, mb_start, 160, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
